// File: rtl/spi_pkg.sv
// Shared state encoding, command codes and frame-length helper for the SPI register bank.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } spi_state_e;

  localparam logic SPI_CMD_WRITE = 1'b1;
  localparam logic SPI_CMD_READ  = 1'b0;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between host (master) and register-bank target (slave).
interface spi_reg_bank_if;
  logic sclk;
  logic sdi;
  logic cs_n;
  logic sdo;

  modport master (output sclk, output sdi, output cs_n, input sdo);
  modport slave  (input sclk, input sdi, input cs_n, output sdo);
endinterface

// File: rtl/spi_sync.sv
// Multi-stage synchroniser for one asynchronous input, plus the preceding sample for edge detection.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic q_prev
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state is written with <= so every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain  <= {STAGES{RST_VAL}};
      q_prev <= RST_VAL;
    end else begin
      chain  <= {chain[STAGES-2:0], d};
      q_prev <= chain[STAGES-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 target giving read/write access to a bank of control registers via oversampled pins.
// Optional read-only status register at address NUM_REGS when SPI_STATUS_REG_EN is defined.
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_reg_bank_if.slave              spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o,
  output logic                       err_o
);

  localparam int FL    = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(FL + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FL);
  localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FL + 1);
  localparam logic [CNT_W-1:0]  CNT_ADDR   = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  CNT_HDR    = CNT_W'(ADDR_W + 1);
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  spi_state_e        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [FL-1:0]     shift;
  logic [DATA_W-1:0] tx;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse;
  logic              err;
  logic              start_pend;

  logic sclk_q, sclk_p, cs_q, cs_p, sdi_q, sdi_prev_unused;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi.sclk), .q(sclk_q), .q_prev(sclk_p));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(spi.cs_n), .q(cs_q), .q_prev(cs_p));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .rst_n(rst_n), .d(spi.sdi), .q(sdi_q), .q_prev(sdi_prev_unused));

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  assign sclk_rise = sclk_q & ~sclk_p;
  assign sclk_fall = ~sclk_q & sclk_p;
  assign cs_rise   = cs_q & ~cs_p;
  assign cs_fall   = ~cs_q & cs_p;

  // Incoming bit stream and the readback trigger on the edge that completes the address field.
  logic [FL-1:0]     shift_next;
  logic [ADDR_W-1:0] rb_addr;
  logic              rb_load;
  assign shift_next = {shift[FL-2:0], sdi_q};
  assign rb_addr    = shift_next[ADDR_W-1:0];
  assign rb_load    = (bit_cnt == CNT_ADDR) && (shift_next[ADDR_W] == SPI_CMD_READ);

  logic              frame_rw;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  logic              frame_full, wr_ok, rd_ok, rd_status, reject;
  assign frame_rw   = shift[FL-1];
  assign frame_addr = shift[DATA_W +: ADDR_W];
  assign frame_data = shift[DATA_W-1:0];
  assign frame_full = (bit_cnt == CNT_FULL);
  assign wr_ok      = frame_full && (frame_rw == SPI_CMD_WRITE) && (frame_addr < NUM_REGS_A);

`ifdef SPI_STATUS_REG_EN
  assign rd_status  = frame_full && (frame_rw == SPI_CMD_READ) && (frame_addr == NUM_REGS_A);
`else
  assign rd_status  = 1'b0;
`endif

  assign rd_ok  = (frame_full && (frame_rw == SPI_CMD_READ) && (frame_addr < NUM_REGS_A)) || rd_status;
  assign reject = !wr_ok && !rd_ok;

`ifdef SPI_STATUS_REG_EN
  logic              sticky_err;
  logic [DATA_W-2:0] err_cnt;
  logic [DATA_W-1:0] status_word;
  assign status_word = {sticky_err, err_cnt};

  // Cleared by a successful status read, otherwise counts rejected frames up to saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_err <= 1'b0;
      err_cnt    <= '0;
    end else if (state == CHECK) begin
      if (rd_status) begin
        sticky_err <= 1'b0;
        err_cnt    <= '0;
      end else if (reject) begin
        sticky_err <= 1'b1;
        if (!(&err_cnt)) err_cnt <= err_cnt + 1'b1;
      end
    end
  end
`endif

  logic [DATA_W-1:0] rd_data;

  // NOTE: combinational blocks assign a default first so no path leaves rd_data holding state (no latch).
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rb_addr == ADDR_W'(k)) rd_data = regs[k];
    end
`ifdef SPI_STATUS_REG_EN
    if (rb_addr == NUM_REGS_A) rd_data = status_word;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      tx         <= '0;
      start_pend <= 1'b0;
      wr_pulse   <= '0;
      err        <= 1'b0;
      // NOTE: the bank drives downstream control logic, so every entry is reset, not left as uninitialised memory.
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      wr_pulse <= '0;
      err      <= 1'b0;
      unique case (state)
        IDLE: begin
          tx <= '0;
          if (cs_fall || start_pend) begin
            state      <= SHIFT;
            bit_cnt    <= '0;
            shift      <= '0;
            start_pend <= 1'b0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= CHECK;
            tx    <= '0;
          end else if (sclk_rise) begin
            shift <= shift_next;
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
            if (rb_load) tx <= rd_data;
          end else if (sclk_fall && (bit_cnt > CNT_HDR)) begin
            // The first fall after the trigger keeps the MSB on sdo for the next host sample.
            tx <= tx << 1;
          end
        end
        CHECK: begin
          state      <= IDLE;
          start_pend <= cs_fall;
          if (wr_ok) begin
            for (int k = 0; k < NUM_REGS; k++) begin
              if (frame_addr == ADDR_W'(k)) begin
                regs[k]     <= frame_data;
                wr_pulse[k] <= 1'b1;
              end
            end
          end else if (reject) begin
            err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_o[k*DATA_W +: DATA_W] = regs[k];
  end

  assign wr_pulse_o = wr_pulse;
  assign err_o      = err;
  assign spi.sdo    = tx[DATA_W-1];

endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomised self-checking bench for spi_reg_bank against a frame-level reference model.
module tb_spi_reg_bank;

  localparam int NREGS = 5;
`ifdef SPI_STATUS_REG_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREGS*8-1:0] regs_o;
  logic [NREGS-1:0]   wr_pulse_o;
  logic               err_o;

  spi_reg_bank_if bus();

  spi_reg_bank #(.NUM_REGS(NREGS), .DATA_W(8), .ADDR_W(7), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi(bus),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o), .err_o(err_o));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Pulse monitor: counts clk cycles each strobe is high.
  int         err_total = 0;
  int         wr_total = 0;
  logic [4:0] wr_last = '0;
  always @(negedge clk) begin
    if (err_o === 1'b1) err_total++;
    if (wr_pulse_o !== '0) begin
      wr_total++;
      wr_last = wr_pulse_o;
    end
  end

  // Reference model: register contents plus the optional status register.
  logic [7:0] m_regs [NREGS];
  logic       m_sticky;
  logic [6:0] m_cnt;

  task automatic model_reset();
    for (int k = 0; k < NREGS; k++) m_regs[k] = 8'h00;
    m_sticky = 1'b0;
    m_cnt    = 7'd0;
  endtask

  task automatic model_frame(input logic [15:0] f, input int nbits,
                             output logic [7:0] exp_rd, output int exp_err, output logic [4:0] exp_wr);
    logic       rw;
    int         addr;
    rw      = f[15];
    addr    = int'(f[14:8]);
    exp_rd  = 8'h00;
    exp_err = 0;
    exp_wr  = '0;
    if (!rw) begin
      if (addr < NREGS) exp_rd = m_regs[addr];
      else if (STATUS_EN && addr == NREGS) exp_rd = {m_sticky, m_cnt};
    end
    if (nbits == 16 && rw && addr < NREGS) begin
      m_regs[addr] = f[7:0];
      exp_wr = 5'(1 << addr);
    end else if (nbits == 16 && !rw && addr < NREGS) begin
      exp_err = 0;
    end else if (nbits == 16 && !rw && STATUS_EN && addr == NREGS) begin
      m_sticky = 1'b0;
      m_cnt    = 7'd0;
    end else begin
      exp_err  = 1;
      m_sticky = 1'b1;
      if (m_cnt != 7'h7F) m_cnt = m_cnt + 7'd1;
    end
  endtask

  function automatic logic [NREGS*8-1:0] model_flat();
    logic [NREGS*8-1:0] v;
    for (int k = 0; k < NREGS; k++) v[k*8 +: 8] = m_regs[k];
    return v;
  endfunction

  // Host side: sclk = clk/10, data changes with sclk low, sdo sampled at each sclk rise.
  task automatic spi_bits(input logic [15:0] frame, input int nbits, output logic [7:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.sdi = (i < 16) ? frame[15-i] : 1'b0;
      repeat (5) @(negedge clk);
      bus.sclk = 1'b1;
      if (i >= 8 && i < 16) rd[15-i] = bus.sdo;
      repeat (5) @(negedge clk);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic spi_xfer(input logic [15:0] frame, input int nbits, output logic [7:0] rd);
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (5) @(negedge clk);
    spi_bits(frame, nbits, rd);
    repeat (5) @(negedge clk);
    bus.cs_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.sclk = 1'b0; bus.sdi = 1'b0; bus.cs_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({regs_o, bus.sdo} !== '0) begin
      failures++; $display("FAIL reset_regs_sdo regs=%h sdo=%b expected all zero", regs_o, bus.sdo);
    end
    checks++;
    if ({wr_pulse_o, err_o} !== '0) begin
      failures++; $display("FAIL reset_strobes wr=%b err=%b expected zero", wr_pulse_o, err_o);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write();
    logic [7:0] rd, exp_rd;
    logic [4:0] exp_wr;
    int exp_err, e0, w0;
    e0 = err_total; w0 = wr_total;
    model_frame(16'h82A5, 16, exp_rd, exp_err, exp_wr);
    spi_xfer(16'h82A5, 16, rd);
    repeat (4) @(negedge clk);
    checks++;
    if (regs_o[2*8 +: 8] !== 8'hA5) begin
      failures++; $display("FAIL write_latency reg2=%h expected=a5 within 4 clk", regs_o[2*8 +: 8]);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (regs_o !== model_flat()) begin
      failures++; $display("FAIL write_regs got=%h expected=%h", regs_o, model_flat());
    end
    checks++;
    if (wr_total - w0 != 1 || wr_last !== 5'b00100) begin
      failures++; $display("FAIL write_strobe cycles=%0d last=%b expected 1 cycle of 00100", wr_total - w0, wr_last);
    end
    checks++;
    if (err_total - e0 != 0) begin
      failures++; $display("FAIL write_err cycles=%0d expected 0", err_total - e0);
    end
    checks++;
    if (rd !== 8'h00) begin
      failures++; $display("FAIL write_sdo got=%h expected 00", rd);
    end
  endtask

  task automatic test_readback();
    logic [7:0] rd, exp_rd;
    logic [4:0] exp_wr;
    int exp_err, e0, w0;
    e0 = err_total; w0 = wr_total;
    model_frame(16'h0200, 16, exp_rd, exp_err, exp_wr);
    spi_xfer(16'h0200, 16, rd);
    repeat (10) @(negedge clk);
    checks++;
    if (rd !== 8'hA5) begin
      failures++; $display("FAIL readback_data got=%h expected a5", rd);
    end
    checks++;
    if (regs_o !== model_flat()) begin
      failures++; $display("FAIL readback_regs got=%h expected=%h", regs_o, model_flat());
    end
    checks++;
    if (wr_total - w0 != 0 || err_total - e0 != 0) begin
      failures++; $display("FAIL readback_strobes wr=%0d err=%0d expected 0 0", wr_total - w0, err_total - e0);
    end
    checks++;
    if (bus.sdo !== 1'b0) begin
      failures++; $display("FAIL readback_sdo_idle got=%b expected 0", bus.sdo);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] rd, exp_rd;
    logic [4:0] exp_wr;
    int exp_err, e0, w0;
    e0 = err_total; w0 = wr_total;
    model_frame(16'h8733, 16, exp_rd, exp_err, exp_wr);
    spi_xfer(16'h8733, 16, rd);
    repeat (10) @(negedge clk);
    checks++;
    if (regs_o !== model_flat()) begin
      failures++; $display("FAIL oor_regs got=%h expected=%h", regs_o, model_flat());
    end
    checks++;
    if (err_total - e0 != 1) begin
      failures++; $display("FAIL oor_err cycles=%0d expected 1", err_total - e0);
    end
    checks++;
    if (wr_total - w0 != 0) begin
      failures++; $display("FAIL oor_strobe cycles=%0d expected 0", wr_total - w0);
    end
  endtask

  task automatic test_short_frame();
    logic [7:0] rd, exp_rd;
    logic [4:0] exp_wr;
    int exp_err, e0, w0;
    e0 = err_total; w0 = wr_total;
    model_frame(16'h8111, 15, exp_rd, exp_err, exp_wr);
    spi_xfer(16'h8111, 15, rd);
    repeat (10) @(negedge clk);
    checks++;
    if (regs_o[1*8 +: 8] !== 8'h00 || err_total - e0 != 1) begin
      failures++; $display("FAIL short_frame reg1=%h err=%0d expected 00 and 1", regs_o[1*8 +: 8], err_total - e0);
    end
    checks++;
    if (wr_total - w0 != 0) begin
      failures++; $display("FAIL short_strobe cycles=%0d expected 0", wr_total - w0);
    end
    e0 = err_total;
    model_frame(16'h81FF, 16, exp_rd, exp_err, exp_wr);
    spi_xfer(16'h81FF, 16, rd);
    repeat (10) @(negedge clk);
    checks++;
    if (regs_o !== model_flat()) begin
      failures++; $display("FAIL short_recover got=%h expected=%h", regs_o, model_flat());
    end
    checks++;
    if (err_total - e0 != 0) begin
      failures++; $display("FAIL short_recover_err cycles=%0d expected 0", err_total - e0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rd, exp_rd;
    logic [4:0] exp_wr;
    int exp_err;
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (5) @(negedge clk);
    spi_bits(16'h8344, 9, rd);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (regs_o !== '0 || bus.sdo !== 1'b0) begin
      failures++; $display("FAIL midreset_state regs=%h sdo=%b expected zero", regs_o, bus.sdo);
    end
    bus.cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    model_frame(16'h8344, 16, exp_rd, exp_err, exp_wr);
    spi_xfer(16'h8344, 16, rd);
    repeat (10) @(negedge clk);
    checks++;
    if (regs_o !== model_flat() || regs_o[3*8 +: 8] !== 8'h44) begin
      failures++; $display("FAIL midreset_recover got=%h expected=%h", regs_o, model_flat());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd, exp_rd, d0, d4;
    logic [4:0] exp_wr;
    int exp_err, e0, w0;
    d0 = 8'($urandom); d4 = 8'($urandom);
    e0 = err_total; w0 = wr_total;
    model_frame({1'b1, 7'd0, d0}, 16, exp_rd, exp_err, exp_wr);
    model_frame({1'b1, 7'd4, d4}, 16, exp_rd, exp_err, exp_wr);
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (5) @(negedge clk);
    spi_bits({1'b1, 7'd0, d0}, 16, rd);
    repeat (5) @(negedge clk);
    bus.cs_n = 1'b1;
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (5) @(negedge clk);
    spi_bits({1'b1, 7'd4, d4}, 16, rd);
    repeat (5) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (regs_o !== model_flat()) begin
      failures++; $display("FAIL b2b_regs got=%h expected=%h", regs_o, model_flat());
    end
    checks++;
    if (wr_total - w0 != 2 || wr_last !== 5'b10000) begin
      failures++; $display("FAIL b2b_strobes cycles=%0d last=%b expected 2 and 10000", wr_total - w0, wr_last);
    end
    checks++;
    if (err_total - e0 != 0) begin
      failures++; $display("FAIL b2b_err cycles=%0d expected 0", err_total - e0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [7:0]  rd, exp_rd, data;
      logic [6:0]  addr;
      logic [4:0]  exp_wr;
      logic [15:0] f;
      logic        rw;
      int exp_err, e0, w0, nbits, sel;
      rw    = 1'($urandom_range(0, 1));
      sel   = $urandom_range(0, 9);
      addr  = (sel == 9) ? 7'($urandom_range(8, 127)) : 7'($urandom_range(0, 6));
      data  = 8'($urandom);
      sel   = $urandom_range(0, 7);
      nbits = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
      f     = {rw, addr, data};
      e0 = err_total; w0 = wr_total;
      model_frame(f, nbits, exp_rd, exp_err, exp_wr);
      spi_xfer(f, nbits, rd);
      repeat (10) @(negedge clk);
      checks++;
      if (regs_o !== model_flat()) begin
        failures++; $display("FAIL rand_regs frame=%h bits=%0d got=%h expected=%h", f, nbits, regs_o, model_flat());
      end
      checks++;
      if (err_total - e0 != exp_err) begin
        failures++; $display("FAIL rand_err frame=%h bits=%0d cycles=%0d expected=%0d", f, nbits, err_total - e0, exp_err);
      end
      checks++;
      if (wr_total - w0 != ((exp_wr != 0) ? 1 : 0) || (exp_wr != 0 && wr_last !== exp_wr)) begin
        failures++; $display("FAIL rand_strobe frame=%h cycles=%0d last=%b expected=%b", f, wr_total - w0, wr_last, exp_wr);
      end
      if (nbits >= 16) begin
        checks++;
        if (rd !== exp_rd) begin
          failures++; $display("FAIL rand_sdo frame=%h got=%h expected=%h", f, rd, exp_rd);
        end
      end
    end
  endtask

  task automatic test_status();
    logic [7:0] rd, exp_rd;
    logic [4:0] exp_wr;
    int exp_err, e0;
    model_frame(16'h0500, 16, exp_rd, exp_err, exp_wr);
    spi_xfer(16'h0500, 16, rd);
    repeat (10) @(negedge clk);
    model_frame(16'h8733, 16, exp_rd, exp_err, exp_wr);
    spi_xfer(16'h8733, 16, rd);
    repeat (10) @(negedge clk);
    model_frame(16'h8111, 15, exp_rd, exp_err, exp_wr);
    spi_xfer(16'h8111, 15, rd);
    repeat (10) @(negedge clk);
    e0 = err_total;
    model_frame(16'h0500, 16, exp_rd, exp_err, exp_wr);
    spi_xfer(16'h0500, 16, rd);
    repeat (10) @(negedge clk);
    checks++;
    if (rd !== (STATUS_EN ? 8'h82 : 8'h00)) begin
      failures++; $display("FAIL status_read1 got=%h expected=%h", rd, STATUS_EN ? 8'h82 : 8'h00);
    end
    checks++;
    if (err_total - e0 != (STATUS_EN ? 0 : 1)) begin
      failures++; $display("FAIL status_read1_err cycles=%0d expected=%0d", err_total - e0, STATUS_EN ? 0 : 1);
    end
    model_frame(16'h0500, 16, exp_rd, exp_err, exp_wr);
    spi_xfer(16'h0500, 16, rd);
    repeat (10) @(negedge clk);
    checks++;
    if (rd !== 8'h00) begin
      failures++; $display("FAIL status_read2 got=%h expected 00", rd);
    end
    e0 = err_total;
    model_frame(16'h85FF, 16, exp_rd, exp_err, exp_wr);
    spi_xfer(16'h85FF, 16, rd);
    repeat (10) @(negedge clk);
    checks++;
    if (err_total - e0 != 1 || regs_o !== model_flat()) begin
      failures++; $display("FAIL status_write err=%0d regs=%h expected 1 and %h", err_total - e0, regs_o, model_flat());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_out_of_range();
    test_short_frame();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    test_status();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
